// File: rtl/alu_pkg.sv
// Shared opcodes, FSM state type and defaults for the EX-stage ALU with
// iterative multiply/divide unit.
package alu_pkg;

  localparam logic [3:0] ALU_AND   = 4'b0000;
  localparam logic [3:0] ALU_OR    = 4'b0001;
  localparam logic [3:0] ALU_ADD   = 4'b0010;
  localparam logic [3:0] ALU_SUB   = 4'b0110;
  localparam logic [3:0] ALU_SLT   = 4'b0111;
  localparam logic [3:0] ALU_SLTU  = 4'b1000;
  localparam logic [3:0] ALU_NOR   = 4'b1001;
  localparam logic [3:0] ALU_MULT  = 4'b1010;
  localparam logic [3:0] ALU_MULTU = 4'b1011;
  localparam logic [3:0] ALU_DIV   = 4'b1100;
  localparam logic [3:0] ALU_DIVU  = 4'b1101;
  localparam logic [3:0] ALU_MFHI  = 4'b1110;
  localparam logic [3:0] ALU_MFLO  = 4'b1111;

  localparam logic [31:0] DEBUG_PATTERN_DEFAULT = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {IDLE, MUL, DIV, HOLD} state_t;

  // Opcodes that hand off to the multi-cycle multiply/divide datapath.
  function automatic logic is_mdu_op(input logic [3:0] op);
    return (op == ALU_MULT) || (op == ALU_MULTU) || (op == ALU_DIV) || (op == ALU_DIVU);
  endfunction

endpackage

// File: rtl/mdu_iter.sv
// Iterative multiply/divide datapath: shift-add multiply or restoring divide,
// one bit per cycle, WIDTH cycles after start. Signed ops run on magnitudes
// and are sign-corrected on the final step, which is presented combinationally
// alongside done so the caller can register it on that same edge.
module mdu_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             abort,
  input  logic             start,
  input  logic             is_div,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out
);

  localparam int CW = $clog2(WIDTH);

  logic             busy;
  logic [CW-1:0]    count;
  logic             div_q, neg_q, neg_rem_q, zero_q;
  logic [WIDTH-1:0] acc, shreg, opnd;
  logic [WIDTH-1:0] acc_nx, shreg_nx;
  logic [WIDTH:0]   sum, trial, diff;
  logic [2*WIDTH-1:0] prod, prod_s;
  logic             sa, sb;
  logic [WIDTH-1:0] mag_a, mag_b;

  assign sa    = is_signed & a[WIDTH-1];
  assign sb    = is_signed & b[WIDTH-1];
  assign mag_a = sa ? (~a + 1'b1) : a;
  assign mag_b = sb ? (~b + 1'b1) : b;

  assign done  = busy && (count == CW'(WIDTH - 1));

  // One iteration step plus the sign-corrected view of its outcome.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    acc_nx   = acc;
    shreg_nx = shreg;
    sum      = {1'b0, acc} + (shreg[0] ? {1'b0, opnd} : '0);
    trial    = {acc, shreg[WIDTH-1]};
    diff     = trial - {1'b0, opnd};
    if (div_q) begin
      // Borrow clear means the trial remainder covers the divisor.
      acc_nx   = diff[WIDTH] ? trial[WIDTH-1:0] : diff[WIDTH-1:0];
      shreg_nx = {shreg[WIDTH-2:0], ~diff[WIDTH]};
    end else begin
      acc_nx   = sum[WIDTH:1];
      shreg_nx = {sum[0], shreg[WIDTH-1:1]};
    end
    prod   = {acc_nx, shreg_nx};
    prod_s = neg_q ? (~prod + 1'b1) : prod;
    if (div_q) begin
      // Divide by zero leaves the remainder equal to the dividend; the quotient is forced to all-ones.
      lo_out = zero_q ? '1 : (neg_q ? (~shreg_nx + 1'b1) : shreg_nx);
      hi_out = neg_rem_q ? (~acc_nx + 1'b1) : acc_nx;
    end else begin
      lo_out = prod_s[WIDTH-1:0];
      hi_out = prod_s[2*WIDTH-1:WIDTH];
    end
  end

  // Operand latch on start, then WIDTH iteration steps; abort drops the op.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst_n) begin
      busy      <= 1'b0;
      count     <= '0;
      div_q     <= 1'b0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      zero_q    <= 1'b0;
      acc       <= '0;
      shreg     <= '0;
      opnd      <= '0;
    end else if (abort) begin
      busy  <= 1'b0;
      count <= '0;
    end else if (start) begin
      busy      <= 1'b1;
      count     <= '0;
      div_q     <= is_div;
      neg_q     <= sa ^ sb;
      neg_rem_q <= sa;
      zero_q    <= is_div && (b == '0);
      acc       <= '0;
      shreg     <= is_div ? mag_a : mag_b;
      opnd      <= is_div ? mag_b : mag_a;
    end else if (busy) begin
      acc   <= acc_nx;
      shreg <= shreg_nx;
      count <= count + 1'b1;
      if (done) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_mdu.sv
// EX-stage ALU with registered single-cycle ops and an iterative MULT/DIV unit
// owning the architectural HI/LO registers, behind valid/ready handshakes.
module alu_mdu
  import alu_pkg::*;
#(
  parameter int          WIDTH         = 32,
  parameter logic [31:0] DEBUG_PATTERN = DEBUG_PATTERN_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] src1,
  input  logic [WIDTH-1:0] src2,
  input  logic [3:0]       ALU_control,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  state_t           state;
  logic             accept, mdu_start, mdu_done;
  logic [WIDTH-1:0] alu_res, mdu_hi, mdu_lo;

  assign in_ready  = (state == IDLE) && (!out_valid || out_ready);
  assign accept    = in_valid && in_ready;
  assign mdu_start = accept && !flush && is_mdu_op(ALU_control);

  mdu_iter #(.WIDTH(WIDTH)) u_mdu (
    .clk       (clk),
    .rst_n     (rst_n),
    .abort     (flush),
    .start     (mdu_start),
    .is_div    ((ALU_control == ALU_DIV) || (ALU_control == ALU_DIVU)),
    .is_signed ((ALU_control == ALU_MULT) || (ALU_control == ALU_DIV)),
    .a         (src1),
    .b         (src2),
    .done      (mdu_done),
    .hi_out    (mdu_hi),
    .lo_out    (mdu_lo)
  );

  // Single-cycle result selection; unused opcodes return the debug pattern.
  always_comb begin
    alu_res = WIDTH'(DEBUG_PATTERN);
    case (ALU_control)
      ALU_AND:  alu_res = src1 & src2;
      ALU_OR:   alu_res = src1 | src2;
      ALU_ADD:  alu_res = src1 + src2;
      ALU_SUB:  alu_res = src1 - src2;
      ALU_SLT:  alu_res = WIDTH'($signed(src1) < $signed(src2));
      ALU_SLTU: alu_res = WIDTH'(src1 < src2);
      ALU_NOR:  alu_res = ~(src1 | src2);
      ALU_MFHI: alu_res = hi;
      ALU_MFLO: alu_res = lo;
      default:  alu_res = WIDTH'(DEBUG_PATTERN);
    endcase
  end

  // Control FSM with registered result, output handshake and HI/LO update.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      result    <= '0;
      hi        <= '0;
      lo        <= '0;
    end else if (flush) begin
      state     <= IDLE;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            if (ALU_control == ALU_MULT || ALU_control == ALU_MULTU) begin
              state     <= MUL;
              out_valid <= 1'b0;
            end else if (ALU_control == ALU_DIV || ALU_control == ALU_DIVU) begin
              state     <= DIV;
              out_valid <= 1'b0;
            end else begin
              result    <= alu_res;
              out_valid <= 1'b1;
            end
          end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
          end else if (out_valid) begin
            state <= HOLD;
          end
        end
        MUL, DIV: begin
          if (mdu_done) begin
            hi        <= mdu_hi;
            lo        <= mdu_lo;
            result    <= mdu_lo;
            out_valid <= 1'b1;
            state     <= IDLE;
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mdu.sv
// Directed self-checking bench for alu_mdu (WIDTH=32).
module tb_alu_mdu;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] src1, src2, result, hi, lo;
  logic [3:0]  ALU_control;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  alu_mdu #(.WIDTH(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .src1        (src1),
    .src2        (src2),
    .ALU_control (ALU_control),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .result      (result),
    .hi          (hi),
    .lo          (lo)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    ALU_control = op;
    src1        = a;
    src2        = b;
    in_valid    = 1'b1;
  endtask

  // Issue a MULT/DIV op, wait a bounded time for its result, check latency/HI/LO.
  task automatic run_mdu(input string tag, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int  cyc;
    logic busy_ready;
    drive(op, a, b);
    tick();
    in_valid   = 1'b0;
    cyc        = 1;
    busy_ready = 1'b0;
    while (!out_valid && cyc < 100) begin
      if (in_ready) busy_ready = 1'b1;
      tick();
      cyc++;
    end
    check({tag, " latency"}, 64'(cyc), 64'd33);
    check({tag, " in_ready busy"}, 64'(busy_ready), 64'd0);
    check({tag, " hi"}, 64'(hi), 64'(exp_hi));
    check({tag, " lo"}, 64'(lo), 64'(exp_lo));
    check({tag, " result"}, 64'(result), 64'(exp_lo));
    tick();
    check({tag, " drained"}, 64'(out_valid), 64'd0);
  endtask

  logic [3:0]  s_op  [10] = '{ALU_ADD, ALU_SUB, ALU_SLT, ALU_SLTU, 4'b0011,
                             ALU_AND, ALU_OR, ALU_NOR, 4'b0100, 4'b0101};
  logic [31:0] s_a   [10] = '{32'd7, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1,
                             32'hF0F0_1234, 32'hF000_0000, 32'hA5A5_A5A5, 32'd9, 32'd9};
  logic [31:0] s_b   [10] = '{32'd5, 32'd5, 32'd1, 32'd1, 32'd2,
                             32'h0FF0_FF00, 32'h0000_000F, 32'h0F0F_0F0F, 32'd9, 32'd9};
  logic [31:0] s_exp [10] = '{32'd12, 32'hFFFF_FFFE, 32'd1, 32'd0, 32'hDEAD_BEEF,
                             32'h00F0_1200, 32'hF000_000F, 32'h5050_5050, 32'hDEAD_BEEF, 32'hDEAD_BEEF};

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic seen;
    rst_n     = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    drive(ALU_ADD, 32'd1, 32'd1);
    tick();
    tick();
    check("rst out_valid", 64'(out_valid), 64'd0);
    check("rst result", 64'(result), 64'd0);
    check("rst hi", 64'(hi), 64'd0);
    check("rst lo", 64'(lo), 64'd0);
    in_valid = 1'b0;
    rst_n    = 1'b1;
    tick();
    check("rst in_ready", 64'(in_ready), 64'd1);
    check("rst idle out_valid", 64'(out_valid), 64'd0);

    // Back-to-back single-cycle stream, one result per cycle.
    for (int i = 0; i < 10; i++) begin
      drive(s_op[i], s_a[i], s_b[i]);
      tick();
      check($sformatf("stream%0d valid", i), 64'(out_valid), 64'd1);
      check($sformatf("stream%0d result", i), 64'(result), 64'(s_exp[i]));
    end
    in_valid = 1'b0;
    tick();
    check("stream drained", 64'(out_valid), 64'd0);
    check("stream hi untouched", 64'(hi), 64'd0);

    run_mdu("MULT -3*7", ALU_MULT, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    run_mdu("MULTU", ALU_MULTU, 32'hFFFF_FFFF, 32'd2, 32'h0000_0001, 32'hFFFF_FFFE);
    run_mdu("DIV -7/2", ALU_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_mdu("DIVU 10/0", ALU_DIVU, 32'd10, 32'd0, 32'd10, 32'hFFFF_FFFF);
    run_mdu("DIV -8/0", ALU_DIV, 32'hFFFF_FFF8, 32'd0, 32'hFFFF_FFF8, 32'hFFFF_FFFF);
    run_mdu("DIV min/-1", ALU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000);

    drive(ALU_MFHI, 32'd0, 32'd0);
    tick();
    check("MFHI", 64'(result), 64'd0);
    drive(ALU_MFLO, 32'd0, 32'd0);
    tick();
    check("MFLO", 64'(result), 64'h8000_0000);
    in_valid = 1'b0;
    tick();

    // Backpressure: result held, no new accepts while stalled.
    out_ready = 1'b0;
    drive(ALU_ADD, 32'd100, 32'd23);
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("bp%0d valid", i), 64'(out_valid), 64'd1);
      check($sformatf("bp%0d result", i), 64'(result), 64'd123);
      check($sformatf("bp%0d in_ready", i), 64'(in_ready), 64'd0);
      tick();
    end
    out_ready = 1'b1;
    check("bp release valid", 64'(out_valid), 64'd1);
    tick();
    check("bp transferred", 64'(out_valid), 64'd0);
    check("bp in_ready", 64'(in_ready), 64'd1);
    check("bp hi kept", 64'(hi), 64'd0);
    check("bp lo kept", 64'(lo), 64'h8000_0000);

    // Flush mid-divide leaves HI/LO from the previous op.
    run_mdu("DIVU 59/6", ALU_DIVU, 32'd59, 32'd6, 32'd5, 32'd9);
    drive(ALU_DIV, 32'd100, 32'd3);
    tick();
    in_valid = 1'b0;
    repeat (9) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush out_valid", 64'(out_valid), 64'd0);
    check("flush in_ready", 64'(in_ready), 64'd1);
    check("flush hi", 64'(hi), 64'd5);
    check("flush lo", 64'(lo), 64'd9);
    seen = 1'b0;
    repeat (40) begin
      tick();
      if (out_valid) seen = 1'b1;
    end
    check("flush no late result", 64'(seen), 64'd0);
    check("flush hi later", 64'(hi), 64'd5);
    check("flush lo later", 64'(lo), 64'd9);

    // Accept coinciding with flush is discarded.
    drive(ALU_ADD, 32'd1, 32'd1);
    flush = 1'b1;
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    check("flush+accept dropped", 64'(out_valid), 64'd0);

    drive(ALU_ADD, 32'd2, 32'd2);
    tick();
    in_valid = 1'b0;
    check("post-flush valid", 64'(out_valid), 64'd1);
    check("post-flush result", 64'(result), 64'd4);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
